// File: rtl/imul_wb_buf_pkg.sv
// ----------------------------------------------------------------------------
// imul_wb_buf_pkg
// Shared definitions for the integer-multiplier writeback buffer.
//   IMUL_RES_W       : multiplier result width (bit 64 is the pointer flag)
//   IMUL_FLG_W       : multiplier flag width
//   IMUL_TAG_MAX_W   : widest destination tag an entry can carry; the top
//                      only uses the low TAG_W bits, so TAG_W must not exceed it
//   IMUL_DEF_MUL_LAT : default multiplier latency in clkEn-qualified cycles
//   imul_entry_t     : one buffered writeback {res, flg, tag}
//   imul_make_entry  : helper that assembles an entry from its fields
// ----------------------------------------------------------------------------
package imul_wb_buf_pkg;

   localparam int IMUL_RES_W       = 65;
   localparam int IMUL_FLG_W       = 6;
   localparam int IMUL_TAG_MAX_W   = 16;
   localparam int IMUL_DEF_MUL_LAT = 4;

   typedef struct packed {
      logic [IMUL_RES_W-1:0]     res;
      logic [IMUL_FLG_W-1:0]     flg;
      logic [IMUL_TAG_MAX_W-1:0] tag;
   } imul_entry_t;

   // Builds one entry; keeps the field order in a single place.
   function automatic imul_entry_t imul_make_entry(
      input logic [IMUL_RES_W-1:0]     res,
      input logic [IMUL_FLG_W-1:0]     flg,
      input logic [IMUL_TAG_MAX_W-1:0] tag
   );
      imul_entry_t e;
      e.res = res;
      e.flg = flg;
      e.tag = tag;
      return e;
   endfunction

endpackage

// File: rtl/imul_wb_fifo.sv
// ----------------------------------------------------------------------------
// imul_wb_fifo
// DEPTH-entry FIFO of multiplier writeback entries.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry
//   empty      : no entries stored
//   count_nxt  : occupancy after the current clock edge (used for credit)
// A push while full (and not popping) is dropped and leaves the FIFO unchanged.
// ----------------------------------------------------------------------------
module imul_wb_fifo
   import imul_wb_buf_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  imul_entry_t       push_data,
   input  logic              pop,
   output imul_entry_t       head,
   output logic              empty,
   output logic [CNT_W-1:0]  count_nxt
);

   imul_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Next occupancy: a simultaneous push and pop leaves the count unchanged.
   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop) begin
         count_nxt = count + 1'b1;
      end else if (!do_push && do_pop) begin
         count_nxt = count - 1'b1;
      end
   end

   // Pointers and count; pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_nxt;
      end
   end

   // Storage needs no reset: the head is only observed while non-empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Credit flow control upstream should make an overflowing push impossible.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(push && full && !pop));
      end
   end

endmodule

// File: rtl/imul_wb_buf.sv
// ----------------------------------------------------------------------------
// imul_wb_buf
// Writeback buffer behind a fixed-latency integer multiplier. A tag pipe
// tracks issued multiplies, the result is captured when its tag reaches the
// end of the pipe, flags are merged one cycle later, and the merged entry is
// queued for a writeback port that may refuse (wb_gnt=0).
// Configuration macro: IMUL_WB_BYPASS_EN -- when defined, an entry that finds
// the FIFO empty is presented on wb_* in its merge cycle and skips the FIFO
// if granted.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   clkEn               : pipeline advance enable shared with the multiplier
//   issue_en, issue_tag : multiply issued this cycle and its destination tag
//   Res                 : multiplier result (bit 64 = pointer flag)
//   flg                 : multiplier flags, valid one cycle after Res
//   wb_gnt              : writeback port granted
//   wb_vld              : writeback request with valid data
//   wb_res/wb_flg/wb_tag: writeback payload (zero when wb_vld=0)
//   stall               : issue must hold off; set while in reset
// ----------------------------------------------------------------------------
module imul_wb_buf
   import imul_wb_buf_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 9,
   parameter int MUL_LAT = IMUL_DEF_MUL_LAT
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clkEn,
   input  logic                  issue_en,
   input  logic [TAG_W-1:0]      issue_tag,
   input  logic [IMUL_RES_W-1:0] Res,
   input  logic [IMUL_FLG_W-1:0] flg,
   input  logic                  wb_gnt,
   output logic                  wb_vld,
   output logic [IMUL_RES_W-1:0] wb_res,
   output logic [IMUL_FLG_W-1:0] wb_flg,
   output logic [TAG_W-1:0]      wb_tag,
   output logic                  stall
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int SUM_W = $clog2(DEPTH + MUL_LAT + 2) + 1;

   logic [MUL_LAT-1:0]    stg_vld;
   logic [TAG_W-1:0]      stg_tag [MUL_LAT];
   logic [MUL_LAT-1:0]    stg_vld_nxt;
   logic                  capture;
   logic                  pend_vld;
   logic [IMUL_RES_W-1:0] pend_res;
   logic [TAG_W-1:0]      pend_tag;
   imul_entry_t           merge_ent;
   imul_entry_t           fifo_head;
   imul_entry_t           out_ent;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      count_nxt;
   logic                  bypass;
   logic                  push;
   logic                  pop;
   logic [SUM_W-1:0]      inflight_nxt;
   logic                  unused_tag_bits;

   // Tag pipe: one {valid,tag} stage per multiplier cycle, advancing only with
   // clkEn so it stays aligned with the multiplier; an issue without clkEn
   // never enters the pipe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_vld <= '0;
         for (int i = 0; i < MUL_LAT; i++) begin
            stg_tag[i] <= '0;
         end
      end else if (clkEn) begin
         stg_vld[0] <= issue_en;
         stg_tag[0] <= issue_tag;
         for (int i = 1; i < MUL_LAT; i++) begin
            stg_vld[i] <= stg_vld[i-1];
            stg_tag[i] <= stg_tag[i-1];
         end
      end
   end

   assign capture = stg_vld[MUL_LAT-1] && clkEn;

   // Pending merge slot: holds Res and tag for exactly one cycle while the
   // flags arrive; back-to-back captures simply reload it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_vld <= 1'b0;
         pend_res <= '0;
         pend_tag <= '0;
      end else begin
         pend_vld <= capture;
         if (capture) begin
            pend_res <= Res;
            pend_tag <= stg_tag[MUL_LAT-1];
         end
      end
   end

   // Flags are taken live in the merge cycle whether or not clkEn is high.
   assign merge_ent = imul_make_entry(pend_res, flg, IMUL_TAG_MAX_W'(pend_tag));

`ifdef IMUL_WB_BYPASS_EN
   assign bypass = pend_vld && fifo_empty;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed entry that is granted never enters the FIFO.
   assign push = pend_vld && !(bypass && wb_gnt);
   assign pop  = wb_gnt && !fifo_empty;

   imul_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (merge_ent),
      .pop       (pop),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count_nxt (count_nxt)
   );

   // Payload is forced to zero when idle so nothing stale shows during reset.
   assign out_ent         = bypass ? merge_ent : fifo_head;
   assign wb_vld          = !fifo_empty || bypass;
   assign wb_res          = wb_vld ? out_ent.res : '0;
   assign wb_flg          = wb_vld ? out_ent.flg : '0;
   assign wb_tag          = wb_vld ? out_ent.tag[TAG_W-1:0] : '0;
   assign unused_tag_bits = ^out_ent.tag;

   // Next-state view of the pipe, so the registered stall reflects the
   // occupancy of the cycle in which it is seen.
   always_comb begin
      stg_vld_nxt = stg_vld;
      if (clkEn) begin
         stg_vld_nxt[0] = issue_en;
         for (int i = 1; i < MUL_LAT; i++) begin
            stg_vld_nxt[i] = stg_vld[i-1];
         end
      end
      inflight_nxt = SUM_W'(capture);
      for (int i = 0; i < MUL_LAT; i++) begin
         inflight_nxt = inflight_nxt + SUM_W'(stg_vld_nxt[i]);
      end
   end

   // Credit stall: everything already buffered or still on its way counts
   // against the FIFO, leaving one entry of slack for the issue in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall <= 1'b1;
      end else begin
         stall <= (SUM_W'(count_nxt) + inflight_nxt) >= SUM_W'(DEPTH - 1);
      end
   end

endmodule

// File: tb/tb_imul_wb_buf.sv
// ----------------------------------------------------------------------------
// tb_imul_wb_buf
// Scoreboard bench for imul_wb_buf. A small multiplier model produces Res and
// flg with the multiplier's timing; each accepted issue pushes its expected
// writeback, and a negedge monitor compares every presented writeback.
// ----------------------------------------------------------------------------
module tb_imul_wb_buf;
   import imul_wb_buf_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TAG_W   = 9;
   localparam int MUL_LAT = 4;
`ifdef IMUL_WB_BYPASS_EN
   localparam int EXP_LAT = MUL_LAT + 1;
`else
   localparam int EXP_LAT = MUL_LAT + 2;
`endif

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [64:0]      res;
      logic [5:0]       flg;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             clkEn;
   logic             issue_en;
   logic [TAG_W-1:0] issue_tag;
   logic [64:0]      Res;
   logic [5:0]       flg;
   logic             wb_gnt;
   logic             wb_vld;
   logic [64:0]      wb_res;
   logic [5:0]       wb_flg;
   logic [TAG_W-1:0] wb_tag;
   logic             stall;

   exp_t               sb [$];
   exp_t               vecs [8];
   logic [MUL_LAT-1:0] m_vld;
   exp_t               m_ent [MUL_LAT];
   logic               p_vld;
   exp_t               p_ent;
   int                 tests = 0;
   int                 fails = 0;
   int                 cyc = 0;
   int                 last_wb_cyc = -1;

   imul_wb_buf #(
      .DEPTH   (DEPTH),
      .TAG_W   (TAG_W),
      .MUL_LAT (MUL_LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clkEn     (clkEn),
      .issue_en  (issue_en),
      .issue_tag (issue_tag),
      .Res       (Res),
      .flg       (flg),
      .wb_gnt    (wb_gnt),
      .wb_vld    (wb_vld),
      .wb_res    (wb_res),
      .wb_flg    (wb_flg),
      .wb_tag    (wb_tag),
      .stall     (stall)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency measurement.
   always @(posedge clk) cyc = cyc + 1;

   // One comparison: counts it and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives one cycle of inputs (called just after a rising edge), lets the
   // DUT sample them, then advances the multiplier model.
   task automatic applyStimulus(input logic ie, input exp_t v, input logic ce, input logic g);
      issue_en  = ie;
      issue_tag = v.tag;
      clkEn     = ce;
      wb_gnt    = g;
      Res       = m_vld[MUL_LAT-1] ? m_ent[MUL_LAT-1].res : 65'h0_DEAD_BEEF_DEAD_BEEF;
      flg       = p_vld ? p_ent.flg : 6'b101010;
      if (ie && ce) sb.push_back(v);
      @(posedge clk);
      p_vld = m_vld[MUL_LAT-1] && ce;
      p_ent = m_ent[MUL_LAT-1];
      if (ce) begin
         for (int i = MUL_LAT - 1; i > 0; i--) begin
            m_vld[i] = m_vld[i-1];
            m_ent[i] = m_ent[i-1];
         end
         m_vld[0] = ie;
         m_ent[0] = v;
      end
      #1;
   endtask

   task automatic idle(input logic ce, input logic g);
      applyStimulus(1'b0, '0, ce, g);
   endtask

   task automatic clearModel();
      sb.delete();
      m_vld = '0;
      p_vld = 1'b0;
   endtask

   // Monitor: whenever a writeback is presented it must match the oldest
   // expected entry; it is retired only when granted.
   always @(negedge clk) begin
      if (!rst && wb_vld) begin
         checkOutput("sb_has_entry", (sb.size() != 0), 1'b1);
         if (sb.size() != 0) begin
            checkOutput("wb_tag", wb_tag, sb[0].tag);
            checkOutput("wb_res", wb_res, sb[0].res);
            checkOutput("wb_flg", wb_flg, sb[0].flg);
            if (wb_gnt) begin
               void'(sb.pop_front());
               last_wb_cyc = cyc;
            end
         end
      end
   end

   // Guards against a hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence.
   initial begin
      int n;
      int issue_cyc;
      logic [7:0] pat;
      vecs[0] = '{9'h01A, 65'h0_0000_0000_0000_0006, 6'b000011};
      vecs[1] = '{9'h101, 65'h1_0000_0000_0000_8000, 6'b100000};
      vecs[2] = '{9'h0FF, 65'h0_FFFF_FFFF_FFFF_FFFF, 6'b010101};
      vecs[3] = '{9'h002, 65'h1_1234_5678_9ABC_DEF0, 6'b111111};
      vecs[4] = '{9'h1FF, 65'h0_0000_0000_0000_0000, 6'b000001};
      vecs[5] = '{9'h055, 65'h0_8000_0000_0000_0000, 6'b001100};
      vecs[6] = '{9'h0AA, 65'h1_FFFF_FFFF_FFFF_FFFF, 6'b110000};
      vecs[7] = '{9'h133, 65'h0_0000_0001_0000_0001, 6'b000110};
      pat = 8'b1011_0110;

      rst = 1'b1; clkEn = 1'b0; issue_en = 1'b0; issue_tag = '0;
      Res = '0; flg = '0; wb_gnt = 1'b0;
      clearModel();

      // Reset state and stall release on the first edge after reset.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_wb_vld", wb_vld, 1'b0);
      checkOutput("rst_stall", stall, 1'b1);
      checkOutput("rst_wb_res", wb_res, 65'h0);
      checkOutput("rst_wb_flg", wb_flg, 6'h0);
      checkOutput("rst_wb_tag", wb_tag, 9'h0);
      rst = 1'b0;
      #1;
      checkOutput("stall_before_edge", stall, 1'b1);
      idle(1'b1, 1'b0);
      checkOutput("stall_after_edge", stall, 1'b0);

      // Grant with nothing valid does nothing.
      repeat (3) idle(1'b1, 1'b1);
      checkOutput("idle_gnt_wb_vld", wb_vld, 1'b0);

      // Single issue latency.
      issue_cyc = cyc;
      applyStimulus(1'b1, vecs[0], 1'b1, 1'b1);
      repeat (10) idle(1'b1, 1'b1);
      checkOutput("single_latency", last_wb_cyc - issue_cyc, EXP_LAT);
      checkOutput("single_drained", sb.size(), 0);

      // Back-to-back issues into a blocked port: credit stops at three.
      n = 0;
      for (int k = 0; k < 12; k++) begin
         if (!stall && n < 6) begin
            applyStimulus(1'b1, vecs[1+n], 1'b1, 1'b0);
            n++;
            if (n == 3) checkOutput("stall_at_credit", stall, 1'b1);
         end else begin
            idle(1'b1, 1'b0);
         end
      end
      checkOutput("issued_before_stall", n, 3);
      checkOutput("stall_held", stall, 1'b1);
      checkOutput("buffered_wb_vld", wb_vld, 1'b1);
      for (int k = 0; k < 40 && (n < 6 || sb.size() != 0); k++) begin
         if (!stall && n < 6) begin
            applyStimulus(1'b1, vecs[1+n], 1'b1, 1'b1);
            n++;
         end else begin
            idle(1'b1, 1'b1);
         end
      end
      checkOutput("b2b_issued", n, 6);
      checkOutput("b2b_drained", sb.size(), 0);

      // clkEn low for three cycles while a result sits at the end of the pipe;
      // an issue attempted with clkEn low must be ignored.
      applyStimulus(1'b1, vecs[2], 1'b1, 1'b1);
      applyStimulus(1'b1, vecs[3], 1'b1, 1'b1);
      repeat (3) idle(1'b1, 1'b1);
      idle(1'b0, 1'b1);
      applyStimulus(1'b1, vecs[4], 1'b0, 1'b1);
      idle(1'b0, 1'b1);
      repeat (10) idle(1'b1, 1'b1);
      checkOutput("clken_drained", sb.size(), 0);

      // Fill, then stream with a stuttering grant while issuing more.
      n = 0;
      for (int k = 0; k < 12; k++) begin
         if (!stall && n < 3) begin
            applyStimulus(1'b1, vecs[n], 1'b1, 1'b0);
            n++;
         end else begin
            idle(1'b1, 1'b0);
         end
      end
      checkOutput("full_stall", stall, 1'b1);
      for (int k = 0; k < 60 && !(n == 8 && sb.size() == 0); k++) begin
         if (!stall && n < 8) begin
            applyStimulus(1'b1, vecs[n], 1'b1, pat[k%8]);
            n++;
         end else begin
            idle(1'b1, pat[k%8]);
         end
      end
      checkOutput("stream_issued", n, 8);
      checkOutput("stream_drained", sb.size(), 0);

      // Reset with two buffered and two in flight.
      applyStimulus(1'b1, vecs[4], 1'b1, 1'b0);
      applyStimulus(1'b1, vecs[5], 1'b1, 1'b0);
      repeat (6) idle(1'b1, 1'b0);
      applyStimulus(1'b1, vecs[6], 1'b1, 1'b0);
      applyStimulus(1'b1, vecs[7], 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("midrst_wb_vld", wb_vld, 1'b0);
      checkOutput("midrst_stall", stall, 1'b1);
      checkOutput("midrst_wb_tag", wb_tag, 9'h0);
      clearModel();
      issue_en = 1'b0;
      wb_gnt   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (12) idle(1'b1, 1'b1);
      checkOutput("post_rst_wb_vld", wb_vld, 1'b0);

      // Normal operation after reset, with the pointer flag set.
      applyStimulus(1'b1, vecs[1], 1'b1, 1'b1);
      repeat (10) idle(1'b1, 1'b1);
      checkOutput("post_rst_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imul_wb_buf.md
IMUL_WB_BUF -- requirements
Module: imul_wb_buf

Interface
REQ-001 SHALL have parameter DEPTH, 4, result FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter TAG_W, 9, destination register tag width.
REQ-003 SHALL have parameter MUL_LAT, 4, clkEn-qualified cycles from issue to multiplier result.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 clkEn  in  1  pipeline advance enable, same signal as the multiplier's.
REQ-007 issue_en  in  1  multiply issued to the multiplier this cycle.
REQ-008 issue_tag  in  TAG_W  destination tag of the issued multiply.
REQ-009 Res  in  65  multiplier result; bit 64 is the pointer flag.
REQ-010 flg  in  6  multiplier flags, valid one cycle after Res.
REQ-011 wb_gnt  in  1  writeback port granted this cycle.
REQ-012 wb_vld  out  1  writeback request with valid data.
REQ-013 wb_res  out  65  writeback result.
REQ-014 wb_flg  out  6  writeback flags.
REQ-015 wb_tag  out  TAG_W  writeback destination tag.
REQ-016 stall  out  1  issue must not assert issue_en next cycle.

Function
REQ-017 Tag pipe: MUL_LAT stages of {valid,tag}, shifted only when clkEn=1; stage 0 loads {issue_en,issue_tag}.
REQ-018 Res SHALL be captured with tag when last tag stage valid and clkEn=1 (capture cycle C).
REQ-019 flg SHALL be sampled at C+1 regardless of clkEn and merged with the captured Res/tag into one entry.
REQ-020 Entry write into FIFO at C+1; issue_en with clkEn=0 SHALL be ignored.
REQ-021 FIFO head drives wb_res/wb_flg/wb_tag; wb_vld=1 iff FIFO non-empty (or bypass, REQ-031).
REQ-022 Entry pops when wb_vld && wb_gnt; outputs SHALL hold stable while wb_vld && !wb_gnt.
REQ-023 Simultaneous push and pop SHALL keep count unchanged, including at full and at count=1.
REQ-024 Pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-025 Credit: inflight = valid tag stages + pending merge entry; stall=1 when count+inflight >= DEPTH-1.
REQ-026 Push while full is impossible under REQ-025; if it occurs, entry SHALL be dropped and the FIFO unchanged (verification assertion).
REQ-027 wb_gnt with wb_vld=0 SHALL have no effect.

Reset
REQ-028 rst SHALL clear tag-pipe valids, pending merge, pointers, count immediately.
REQ-029 Under rst: wb_vld=0, stall=1, wb_res/wb_flg/wb_tag=0; stall drops first clk edge after rst deasserts.
REQ-030 Reset mid-operation SHALL discard all in-flight and buffered results without a writeback.

Configuration
REQ-031 With IMUL_WB_BYPASS_EN defined: FIFO empty and merge entry ready -> entry driven combinationally on wb_* same cycle; if wb_gnt, not written to FIFO.
REQ-032 Without IMUL_WB_BYPASS_EN: every entry SHALL pass through the FIFO; writeback earliest C+2.

Structure
REQ-033 Shared package holds IMUL_RES_W=65, IMUL_FLG_W=6, entry struct {res,flg,tag}, default MUL_LAT.
REQ-034 One sub-module imul_wb_fifo (DEPTH x entry, push/pop/count); tag pipe and merge in the top.

Verification
REQ-035 Single issue tag=0x1A, Res=0x0_0000_0000_0000_0006, flg=6'b000011 at C+1, wb_gnt=1 -> wb_vld one cycle at C+2 (C+1 with bypass), tag 0x1A, flags 6'b000011.
REQ-036 Back-to-back 6 issues, wb_gnt=0 -> stall rises once count+inflight=3; 3 entries buffered, none lost; release wb_gnt -> in-order drain.
REQ-037 clkEn=0 for 3 cycles mid-pipeline -> tag/result alignment preserved; tags emerge in issue order.
REQ-038 Full FIFO with concurrent push and pop -> count stays 3, order preserved.
REQ-039 rst asserted with 2 buffered and 2 in flight -> wb_vld=0 immediately, no stale writebacks after release.
REQ-040 Res[64]=1 input -> wb_res[64]=1 at writeback.
